// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator: folds one bit per accepted cycle into an MSB-first LFSR
// and reports the final checksum plus an expected-value comparison at frame end.
module crc8_serial #(
    parameter logic [7:0] POLY  = 8'h07,
    parameter logic [7:0] INIT  = 8'h00,
    parameter int         LEN_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [7:0]       exp_i,
    input  logic             bit_in_i,
    input  logic             bit_valid_i,
    output logic             bit_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       crc_out_o,
    output logic             match_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       crc_q, crc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       exp_q, exp_d;
    logic [7:0]       crc_out_q, crc_out_d;
    logic             match_q, match_d;

    logic             accept;
    logic [7:0]       crc_step;

    assign accept   = (state_q == SHIFT) && bit_valid_i;
    assign crc_step = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ bit_in_i) ? POLY : 8'h00);

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        crc_out_d = crc_out_q;
        match_d   = match_q;
        unique case (state_q)
            IDLE: begin
                if (start_i && (len_i != '0)) begin
                    crc_d   = INIT;
                    cnt_d   = len_i;
                    exp_d   = exp_i;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    crc_d = crc_step;
                    cnt_d = cnt_q - 1'b1;
                    // Result is published on the last accept so it is visible during DONE.
                    if (cnt_q == LEN_W'(1)) begin
                        crc_out_d = crc_step;
                        match_d   = (crc_step == exp_q);
                        state_d   = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            cnt_q     <= '0;
            exp_q     <= 8'h00;
            crc_out_q <= 8'h00;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            crc_out_q <= crc_out_d;
            match_q   <= match_d;
        end
    end

    assign bit_ready_o = (state_q == SHIFT);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign crc_out_o   = crc_out_q;
    assign match_o     = match_q;

endmodule

// File: tb/tb_crc8_serial.sv
// Scoreboard bench for crc8_serial: the driver queues the expected result of each frame,
// a negedge monitor checks every done pulse and that crc_out holds between pulses.
module tb_crc8_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic [7:0] exp_in;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       busy;
    logic       done;
    logic [7:0] crc_out;
    logic       match;

    always #5 clk = ~clk;

    crc8_serial #(.POLY(8'h07), .INIT(8'h00), .LEN_W(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .len_i(len), .exp_i(exp_in),
        .bit_in_i(bit_in), .bit_valid_i(bit_valid), .bit_ready_o(bit_ready),
        .busy_o(busy), .done_o(done), .crc_out_o(crc_out), .match_o(match)
    );

    typedef struct {
        logic [7:0] crc;
        logic       m;
        int         start_edge;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic       rst_at_edge = 1'b0;
    logic [7:0] last_crc = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst_n;
    end

    // Monitor: pop and compare on every done pulse; otherwise crc_out must hold.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("crc_out", 32'(crc_out), 32'(e.crc));
                chk("match", 32'(match), 32'(e.m));
                chk("done_latency", 32'(cyc - e.start_edge + 1), 32'(e.lat));
                chk("ready_in_done", 32'(bit_ready), 32'd0);
                chk("busy_in_done", 32'(busy), 32'd1);
            end
        end else if (rst_at_edge === 1'b1) begin
            chk("crc_hold", 32'(crc_out), 32'(last_crc));
        end
        last_crc = crc_out;
    end

    // Drives one 8-bit frame MSB first; returns at the first cycle a new start is legal.
    task automatic frame(input logic [7:0] data, input logic [7:0] xp, input logic [7:0] xcrc,
                         input bit bub, input int lat, input bit poke);
        int k;
        bit ph;
        start  = 1'b1;
        len    = 4'd8;
        exp_in = xp;
        sb.push_back('{xcrc, (xcrc == xp), cyc + 1, lat});
        @(negedge clk);
        start = 1'b0;
        chk("ready_first", 32'(bit_ready), 32'd1);
        chk("busy_first", 32'(busy), 32'd1);
        k  = 0;
        ph = 1'b0;
        while (k < 8) begin
            if (bub && ph) begin
                bit_valid = 1'b0;
                bit_in    = ~data[0];
            end else begin
                bit_valid = 1'b1;
                bit_in    = data[7-k];
                k++;
            end
            start = poke && (k == 3);
            ph    = !ph;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        exp_in    = 8'h00;
        bit_in    = 1'b0;
        bit_valid = 1'b0;

        // Reset with random inputs
        repeat (2) begin
            start     = 1'($urandom);
            len       = 4'($urandom);
            exp_in    = 8'($urandom);
            bit_in    = 1'($urandom);
            bit_valid = 1'($urandom);
            @(negedge clk);
        end
        chk("rst_ready", 32'(bit_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_crc", 32'(crc_out), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        start     = 1'b0;
        bit_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        // Zero-length start is ignored
        start = 1'b1;
        len   = 4'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            chk("len0_busy", 32'(busy), 32'd0);
            chk("len0_ready", 32'(bit_ready), 32'd0);
            @(negedge clk);
        end

        frame(8'h80, 8'h89, 8'h89, 1'b0, 9, 1'b0);
        frame(8'h01, 8'h00, 8'h07, 1'b0, 9, 1'b0);
        frame(8'h00, 8'h00, 8'h00, 1'b0, 9, 1'b0);
        frame(8'h80, 8'h89, 8'h89, 1'b1, 16, 1'b1);

        // Reset after 4 of 8 bits aborts the frame
        start  = 1'b1;
        len    = 4'd8;
        exp_in = 8'h89;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            bit_in    = (i == 0);
            @(negedge clk);
        end
        bit_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("abort_crc", 32'(crc_out), 32'd0);
        chk("abort_match", 32'(match), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(bit_ready), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        frame(8'h01, 8'h07, 8'h07, 1'b0, 9, 1'b0);

        // Back-to-back at the earliest legal start
        frame(8'h80, 8'h89, 8'h89, 1'b0, 9, 1'b0);
        frame(8'h01, 8'h00, 8'h07, 1'b0, 9, 1'b0);

        repeat (3) @(negedge clk);
        chk("frames_completed", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc8_serial.md
# crc8_serial

Bit-serial CRC-8 accumulator that consumes the single-bit stream produced by the team's gate-level XOR / parity cells and reduces a frame of 1..(2^LEN_W − 1) bits to an 8-bit checksum. It sits directly downstream of the XOR datapath: each accepted bit is folded into an 8-bit LFSR whose feedback taps are XOR stages. At frame end it pulses `done`, presents the CRC, and flags whether it equals an expected value.

## Interface
Parameters:
- `POLY`, 8'h07, generator polynomial (x^8 term implicit), MSB-first.
- `INIT`, 8'h00, LFSR seed loaded at frame start.
- `LEN_W`, 4, width of the frame-length input; max frame = 2^LEN_W − 1 bits.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  frame start request; sampled only in IDLE.
- `len`  in  LEN_W  frame length in bits, sampled with `start`.
- `exp`  in  8  expected CRC, sampled with `start`.
- `bit_in`  in  1  serial data bit, MSB of frame first.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_ready`  out  1  block accepts a bit this cycle (registered).
- `busy`  out  1  high from the cycle after accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse: frame complete.
- `crc_out`  out  8  final CRC; updated with `done`, held until next `done`.
- `match`  out  1  `crc_out == exp`; updated with `done`, held.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `bit_ready`=0, `busy`=0. If `start`=1 and `len`≠0: load crc←INIT, cnt←len, latch `exp`; → SHIFT. `start` with `len`=0 ignored (stay IDLE, no `done`).
- SHIFT: `bit_ready`=1, `busy`=1. Bit accepted iff `bit_valid`&&`bit_ready`. On accept: fb = crc[7] ^ `bit_in`; crc ← {crc[6:0],0} ^ (fb ? POLY : 0); cnt ← cnt − 1. Accept with cnt==1 → DONE. No accept → hold all state (bubbles allowed indefinitely).
- DONE (one cycle): `done`=1, `busy`=1, `bit_ready`=0; `crc_out`←crc, `match`←(crc==exp) are already visible this cycle; → IDLE.
- `start` asserted outside IDLE is ignored; no queuing.
- `bit_valid` outside SHIFT is ignored; no bit consumed.
- Internal counter width LEN_W; never wraps (decrements from ≥1 to 0 only at last accept).

## Timing
- Reset (`rst_n`=0 at rising edge): state←IDLE, `bit_ready`=0, `busy`=0, `done`=0, `crc_out`=8'h00, `match`=0, cnt=0, crc=INIT. Reset mid-frame aborts with no `done`.
- `start` at edge t → SHIFT from t+1; `bit_ready`=1 first at cycle t+1.
- Throughput 1 bit/cycle. Last bit accepted at edge k → `done`=1, `crc_out`/`match` valid during cycle k+1; IDLE at k+2. Back-to-back `start` accepted at k+2 earliest.
- Minimum frame latency (no bubbles): `start` to `done` = len + 1 cycles.
- `crc_out`, `match` stable between `done` pulses, including across a new frame in progress.

## Test plan
- Reset: hold `rst_n`=0 two cycles with random inputs → all outputs 0, `bit_ready`=0; `start` with `len`=0 afterwards → no `busy`, no `done`.
- Byte 8'h80, `len`=8, `exp`=8'h89, `bit_valid` continuous → `done` 9 cycles after `start`, `crc_out`=8'h89, `match`=1.
- Byte 8'h01, `len`=8, `exp`=8'h00 → `crc_out`=8'h07, `match`=0; byte 8'h00 → `crc_out`=8'h00.
- 8'h80 with `bit_valid` deasserted every other cycle → same `crc_out`=8'h89, `done` 16 cycles after `start`; `start` pulsed during SHIFT ignored.
- Reset asserted after 4 of 8 bits → no `done`, outputs return to reset values; fresh 8'h01 frame then yields 8'h07.
- Back-to-back frames 8'h80 then 8'h01 with `start` at earliest legal cycle → two `done` pulses, 8'h89 then 8'h07, `crc_out` holds 8'h89 throughout second frame.
